// File: rtl/lsu_bus_master_pkg.sv
// lsu_bus_master_pkg
// Shared definitions for the load/store bus master: RV32I funct3 codes,
// memory write-enable encodings, address region nibbles, FSM state encoding
// and small decode helpers.
package lsu_bus_master_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_WORD = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_BYTE = 3'b100;

  localparam logic [3:0] REGION_ROM = 4'h0;
  localparam logic [3:0] REGION_RAM = 4'h1;
  localparam logic [3:0] REGION_IO  = 4'h2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } lsu_state_e;

  // Write-enable pattern for a store; only the three legal store sizes map
  // to a nonzero value.
  function automatic logic [2:0] store_we(input logic [2:0] funct3);
    case (funct3)
      F3_W:    store_we = WE_WORD;
      F3_H:    store_we = WE_HALF;
      F3_B:    store_we = WE_BYTE;
      default: store_we = WE_NONE;
    endcase
  endfunction

  // Loads accept B/H/W/BU/HU; stores only B/H/W (no unsigned stores).
  function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
    logic bad;
    bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    funct3_illegal = bad || (we && funct3[2]);
  endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// lsu_bus_master_if
// Groups the core-side request/response handshake and the memory data-port
// signals of the load/store bus master.
//   master : the lsu side (drives req_ready, resp_*, mem_addr/we/data_in)
//   slave  : the environment (core + memory) side
interface lsu_bus_master_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  logic [31:0] mem_addr;
  logic [2:0]  mem_write_enable;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_addr, mem_write_enable, mem_data_in
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_addr, mem_write_enable, mem_data_in
  );

endinterface

// File: rtl/lsu_bus_master_load_ext.sv
// lsu_load_ext
// Combinational sign/zero extension of load data returned by the memory.
// The memory has already shifted the addressed byte/half down to bit 0.
//   funct3 : load size/signedness (LB/LH/LW/LBU/LHU)
//   raw    : memory read data
//   data   : extended result
module lsu_load_ext
  import lsu_bus_master_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (funct3)
      F3_B:    data = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   data = {24'b0, raw[7:0]};
      F3_H:    data = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   data = {16'b0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// lsu_bus_master
// Load/store initiator between the core execute stage and the memory data
// port. One request per handshake; the memory-side write enable is driven
// for exactly one cycle, load data is extended and returned as a registered
// one-cycle response with a fault flag.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : lsu_bus_master_if.master (req_*, resp_*, mem_*)
// Build option:
//   MISALIGN_CHECK_EN : when defined, misaligned half/word accesses fault
//                       instead of being passed to the memory as-is.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// ISSUE | memory access cycle, write enable asserted for stores
// RESP  | response pulse; may accept the next request in the same cycle
module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter logic [3:0]  ROM_REGION = REGION_ROM,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst_n,
  lsu_bus_master_if.master bus
);

  lsu_state_e  state;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_fault_q;
  logic [2:0]  mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_data_in_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic        fault_q;

  logic        accept;
  logic        misalign;
  logic        fault_now;
  logic [31:0] ext_data;

  assign accept = bus.req_valid & req_ready_q;

`ifdef MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (bus.req_funct3)
      F3_H, F3_HU: misalign = bus.req_addr[0];
      F3_W:        misalign = |bus.req_addr[1:0];
      default:     misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Fault is decided from the request itself so the ISSUE cycle can gate
  // the write enable without any extra decode.
  assign fault_now = funct3_illegal(bus.req_we, bus.req_funct3)
                   | (bus.req_we && (bus.req_addr[31:28] == ROM_REGION))
                   | misalign;

  lsu_load_ext u_load_ext (
    .funct3 (funct3_q),
    .raw    (bus.mem_data_out),
    .data   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'h0;
      resp_fault_q  <= 1'b0;
      mem_we_q      <= WE_NONE;
      mem_addr_q    <= RESET_ADDR;
      mem_data_in_q <= 32'h0;
      funct3_q      <= 3'b000;
      we_q          <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_RESP: begin
          resp_valid_q <= 1'b0;
          if (accept) begin
            state         <= ST_ISSUE;
            req_ready_q   <= 1'b0;
            mem_addr_q    <= bus.req_addr;
            mem_data_in_q <= bus.req_wdata;
            funct3_q      <= bus.req_funct3;
            we_q          <= bus.req_we;
            fault_q       <= fault_now;
            mem_we_q      <= (bus.req_we && !fault_now) ? store_we(bus.req_funct3) : WE_NONE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state        <= ST_RESP;
          req_ready_q  <= 1'b1;
          mem_we_q     <= WE_NONE;
          resp_valid_q <= 1'b1;
          resp_fault_q <= fault_q;
          // Read data is sampled at the edge closing the access cycle.
          resp_rdata_q <= (fault_q || we_q) ? 32'h0 : ext_data;
        end
        default: begin
          state        <= ST_IDLE;
          req_ready_q  <= 1'b1;
          mem_we_q     <= WE_NONE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready        = req_ready_q;
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_rdata       = resp_rdata_q;
  assign bus.resp_fault       = resp_fault_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_write_enable = mem_we_q;
  assign bus.mem_data_in      = mem_data_in_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master
// Self-checking bench: a word memory stub answers the data port, a shadow
// byte model predicts load results, and expected responses are queued at
// accept time and compared when resp_valid appears.
module tb_lsu_bus_master;
  import lsu_bus_master_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  lsu_bus_master_if bus();

  lsu_bus_master #(
    .ROM_REGION (4'h0),
    .RESET_ADDR (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory stub: combinational read shifted by addr[1:0], write on clock.
  logic [31:0] mem_words [0:255];
  logic [7:0]  shadow    [0:1023];

  assign bus.mem_data_out = mem_words[bus.mem_addr[9:2]] >> {bus.mem_addr[1:0], 3'b000};

  always @(posedge clk) begin
    case (bus.mem_write_enable)
      3'b001: mem_words[bus.mem_addr[9:2]] <= bus.mem_data_in;
      3'b010: begin
        if (bus.mem_addr[1]) mem_words[bus.mem_addr[9:2]][31:16] <= bus.mem_data_in[15:0];
        else                 mem_words[bus.mem_addr[9:2]][15:0]  <= bus.mem_data_in[15:0];
      end
      3'b100: begin
        case (bus.mem_addr[1:0])
          2'd0: mem_words[bus.mem_addr[9:2]][7:0]   <= bus.mem_data_in[7:0];
          2'd1: mem_words[bus.mem_addr[9:2]][15:8]  <= bus.mem_data_in[7:0];
          2'd2: mem_words[bus.mem_addr[9:2]][23:16] <= bus.mem_data_in[7:0];
          default: mem_words[bus.mem_addr[9:2]][31:24] <= bus.mem_data_in[7:0];
        endcase
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    string       tag;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Expected load value from the shadow byte model.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] raw;
    logic [9:0]  base;
    int          off;
    base = {addr[9:2], 2'b00};
    off  = int'(addr[1:0]);
    raw  = 32'h0;
    for (int i = 0; i < 4; i++)
      if (off + i < 4) raw[8*i +: 8] = shadow[base + 10'(off + i)];
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b100:  return {24'h0, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
    logic [9:0] a;
    a = addr[9:0];
    case (f3)
      3'b010: for (int i = 0; i < 4; i++) shadow[{a[9:2], 2'b00} + 10'(i)] = d[8*i +: 8];
      3'b001: for (int i = 0; i < 2; i++) shadow[{a[9:1], 1'b0} + 10'(i)] = d[8*i +: 8];
      default: shadow[a] = d[7:0];
    endcase
  endtask

  // Called at a negedge; leaves req_valid high and returns at the negedge
  // after acceptance. waits = negedges spent with req_ready low.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_fault,
                        input logic [2:0] exp_we, input string tag, output int waits);
    exp_t e;
    waits = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    while (!bus.req_ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 10) begin
      check({tag, "_ready_timeout"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.tag   = tag;
    e.fault = exp_fault;
    if (exp_fault || we) e.rdata = 32'h0;
    else                 e.rdata = model_load(f3, addr);
    if (we && !exp_fault) model_store(f3, addr, wdata);
    sb_q.push_back(e);
    @(negedge clk);
    check({tag, "_we"},    32'(bus.mem_write_enable), 32'(exp_we));
    check({tag, "_addr"},  bus.mem_addr, addr);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_rv"},    32'(bus.resp_valid), 32'd0);
    if (we && !exp_fault) check({tag, "_wdata"}, bus.mem_data_in, wdata);
  endtask

  task automatic drain(input int cycles);
    bus.req_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  // Response monitor and write-enable pulse-width watcher.
  logic [2:0] we_prev = 3'b000;
  always @(negedge clk) begin
    if (rst_n) begin
      if (we_prev != 3'b000) check("we_one_cycle", 32'(bus.mem_write_enable), 32'd0);
      if (bus.resp_valid) begin
        if (sb_q.size() == 0) begin
          check("resp_unexpected", 32'(bus.resp_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check({e.tag, "_rdata"}, bus.resp_rdata, e.rdata);
          check({e.tag, "_fault"}, 32'(bus.resp_fault), 32'(e.fault));
        end
      end
    end
    we_prev = bus.mem_write_enable;
  end

  initial begin
    int w;
    for (int i = 0; i < 256; i++) mem_words[i] = 32'h0;
    for (int i = 0; i < 1024; i++) shadow[i] = 8'h0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    rst_n = 1'b0;
    #12;
    check("rst_ready",   32'(bus.req_ready), 32'd1);
    check("rst_rv",      32'(bus.resp_valid), 32'd0);
    check("rst_rdata",   bus.resp_rdata, 32'h0);
    check("rst_fault",   32'(bus.resp_fault), 32'd0);
    check("rst_we",      32'(bus.mem_write_enable), 32'd0);
    check("rst_addr",    bus.mem_addr, 32'h0);
    check("rst_data_in", bus.mem_data_in, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store/load.
    do_req(1'b1, F3_W, 32'h1000_0004, 32'hDEAD_BEEF, 1'b0, WE_WORD, "sw", w);
    drain(2);
    do_req(1'b0, F3_W, 32'h1000_0004, 32'h0, 1'b0, WE_NONE, "lw", w);
    drain(2);

    // Byte store, signed/unsigned loads.
    do_req(1'b1, F3_B, 32'h1000_0001, 32'h0000_0080, 1'b0, WE_BYTE, "sb", w);
    drain(2);
    do_req(1'b0, F3_B,  32'h1000_0001, 32'h0, 1'b0, WE_NONE, "lb", w);
    drain(2);
    do_req(1'b0, F3_BU, 32'h1000_0001, 32'h0, 1'b0, WE_NONE, "lbu", w);
    drain(2);

    // Half store, signed/unsigned loads.
    do_req(1'b1, F3_H, 32'h1000_0002, 32'h0000_8001, 1'b0, WE_HALF, "sh", w);
    drain(2);
    do_req(1'b0, F3_H,  32'h1000_0002, 32'h0, 1'b0, WE_NONE, "lh", w);
    drain(2);
    do_req(1'b0, F3_HU, 32'h1000_0002, 32'h0, 1'b0, WE_NONE, "lhu", w);
    drain(2);

    // Faults: ROM store, illegal load funct3, unsigned store.
    do_req(1'b1, F3_W,   32'h0000_0010, 32'h1234_5678, 1'b1, WE_NONE, "rom_sw", w);
    drain(2);
    do_req(1'b0, 3'b011, 32'h1000_0004, 32'h0, 1'b1, WE_NONE, "bad_f3", w);
    drain(2);
    do_req(1'b1, 3'b100, 32'h1000_0008, 32'h0000_00AA, 1'b1, WE_NONE, "bad_st", w);
    drain(2);
    // ROM word should still read back as never written.
    do_req(1'b0, F3_W, 32'h0000_0010, 32'h0, 1'b0, WE_NONE, "rom_lw", w);
    drain(2);

    // Back-to-back loads with req_valid held high.
    do_req(1'b0, F3_W,  32'h1000_0004, 32'h0, 1'b0, WE_NONE, "b2b0", w);
    do_req(1'b0, F3_B,  32'h1000_0004, 32'h0, 1'b0, WE_NONE, "b2b1", w);
    check("b2b1_wait", 32'(w), 32'd1);
    do_req(1'b0, F3_HU, 32'h1000_0006, 32'h0, 1'b0, WE_NONE, "b2b2", w);
    check("b2b2_wait", 32'(w), 32'd1);
    do_req(1'b0, F3_BU, 32'h1000_0007, 32'h0, 1'b0, WE_NONE, "b2b3", w);
    check("b2b3_wait", 32'(w), 32'd1);
    drain(3);

    // Misaligned word load.
`ifdef MISALIGN_CHECK_EN
    do_req(1'b0, F3_W, 32'h1000_0002, 32'h0, 1'b1, WE_NONE, "mis_lw", w);
`else
    do_req(1'b0, F3_W, 32'h1000_0002, 32'h0, 1'b0, WE_NONE, "mis_lw", w);
`endif
    drain(3);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of an ISSUE cycle.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h1000_0040;
    bus.req_wdata  = 32'hCAFE_F00D;
    @(posedge clk);
    #2;
    check("rst_mid_we_before", 32'(bus.mem_write_enable), 32'(WE_WORD));
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("rst_mid_we",    32'(bus.mem_write_enable), 32'd0);
    check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mid_addr",  bus.mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_mid_rv", 32'(bus.resp_valid), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_rv", 32'(bus.resp_valid), 32'd0);
    end

    // Normal operation after reset.
    do_req(1'b0, F3_W, 32'h1000_0004, 32'h0, 1'b0, WE_NONE, "post_lw", w);
    drain(3);
    check("sb_final", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
